// File: rtl/resizer_pkg.sv
// resizer_pkg: shared constants, types and helpers for the resizer read side.
// Lane layout inside an entry (lane 0 in the LSBs): {keep, last, data}.
// The lane geometry of entry_to_axis and lane_split is set here.
package resizer_pkg;

    localparam int T_DATA_WIDTH = 8;
    localparam int M_KEEP_WIDTH = 2;
    localparam int CNT_WIDTH    = 16;
    localparam int LANE_SZ      = 2 + T_DATA_WIDTH;
    localparam int KEEP_BIT     = LANE_SZ - 1;
    localparam int LAST_BIT     = LANE_SZ - 2;
    localparam int ENTRY_SZ     = LANE_SZ * M_KEEP_WIDTH;
    localparam int DATA_SZ      = T_DATA_WIDTH * M_KEEP_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // no beat held
        FULL  = 2'd1,  // one beat held
        SPLIT = 2'd2   // beat held plus a pending half-entry
    } state_t;

    // Returns lane idx of an entry as {keep, last, data}.
    function automatic logic [LANE_SZ-1:0] lane_get(input logic [ENTRY_SZ-1:0] entry,
                                                    input int idx);
        return entry[LANE_SZ*idx +: LANE_SZ];
    endfunction

endpackage

// File: rtl/lane_split.sv
// lane_split: combinational classifier for one buffer entry.
// Ports:
//   entry      - raw entry, lanes of {keep, last, data}
//   keep_vec   - keep bit of every lane (K)
//   split      - entry holds a packet end followed by kept lanes of the next packet
//   err        - last on an unkept lane, or more than one kept last in the pending half
//   beat1_keep - keep of the first (or only) beat
//   beat1_last - tlast of the first (or only) beat
//   pend_keep  - keep of the pending second beat (lanes above the first kept last)
//   pend_last  - tlast of the pending second beat
//   data       - lane data packed without control bits; shared by both beats
module lane_split
    import resizer_pkg::*;
(
    input  logic [ENTRY_SZ-1:0]     entry,
    output logic [M_KEEP_WIDTH-1:0] keep_vec,
    output logic                    split,
    output logic                    err,
    output logic [M_KEEP_WIDTH-1:0] beat1_keep,
    output logic                    beat1_last,
    output logic [M_KEEP_WIDTH-1:0] pend_keep,
    output logic                    pend_last,
    output logic [DATA_SZ-1:0]      data
);

    logic [LANE_SZ-1:0]      lane;
    logic [M_KEEP_WIDTH-1:0] last_vec;
    logic [M_KEEP_WIDTH-1:0] kept_last;
    logic [M_KEEP_WIDTH-1:0] low_mask;   // lanes 0..k, all ones when no kept last
    logic [M_KEEP_WIDTH-1:0] pend_kl;
    logic                    found;

    always_comb begin
        lane     = '0;
        keep_vec = '0;
        last_vec = '0;
        data     = '0;
        for (int i = 0; i < M_KEEP_WIDTH; i++) begin
            lane                           = lane_get(entry, i);
            keep_vec[i]                    = lane[KEEP_BIT];
            last_vec[i]                    = lane[LAST_BIT];
            data[i*T_DATA_WIDTH +: T_DATA_WIDTH] = lane[T_DATA_WIDTH-1:0];
        end

        kept_last = keep_vec & last_vec;

        // Walk upwards: every lane up to and including the lowest kept last
        // belongs to the first beat.
        found    = 1'b0;
        low_mask = '0;
        for (int i = 0; i < M_KEEP_WIDTH; i++) begin
            if (!found) begin
                low_mask[i] = 1'b1;
            end
            if (kept_last[i]) begin
                found = 1'b1;
            end
        end

        pend_keep  = keep_vec & ~low_mask;
        pend_kl    = kept_last & ~low_mask;
        split      = found && (pend_keep != '0);
        beat1_keep = split ? (keep_vec & low_mask) : keep_vec;
        beat1_last = found;
        pend_last  = |pend_kl;

        // A pending half with two packet ends cannot be split again; flag it.
        err = ((last_vec & ~keep_vec) != '0) ||
              (split && ((pend_kl & (pend_kl - M_KEEP_WIDTH'(1))) != '0));
    end

endmodule

// File: rtl/entry_to_axis.sv
// entry_to_axis: drains buffer entries and emits them as AXI-Stream beats.
// Empty entries are dropped; an entry holding a packet end followed by lanes
// of the next packet is emitted as two beats.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   entry_in        - entry from the buffer, lanes of {keep, last, data}
//   entry_valid     - entry present (buffer not underflowing)
//   entry_ready     - entry consumed this cycle when entry_valid is also high
//   m_axis_*        - AXI-Stream master beat
//   pkt_count       - count of tlast handshakes, wrapping
//   proto_err       - sticky protocol error, cleared only by rst
//   fsm_state       - current FSM state (EMPTY/FULL/SPLIT) for observation
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a raised m_axis_tvalid holds its beat stable until taken, and
// entry_ready may depend combinationally on m_axis_tready.
module entry_to_axis
    import resizer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ENTRY_SZ-1:0]     entry_in,
    input  logic                    entry_valid,
    output logic                    entry_ready,
    output logic [DATA_SZ-1:0]      m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic                    proto_err,
    output logic [1:0]              fsm_state
);

    state_t                  state;
    logic [M_KEEP_WIDTH-1:0] hold_keep;
    logic                    hold_last;

    logic [M_KEEP_WIDTH-1:0] keep_vec;
    logic                    split;
    logic                    err;
    logic [M_KEEP_WIDTH-1:0] beat1_keep;
    logic                    beat1_last;
    logic [M_KEEP_WIDTH-1:0] pend_keep;
    logic                    pend_last;
    logic [DATA_SZ-1:0]      data;

    logic accept;
    logic take;

    lane_split u_lane_split (
        .entry      (entry_in),
        .keep_vec   (keep_vec),
        .split      (split),
        .err        (err),
        .beat1_keep (beat1_keep),
        .beat1_last (beat1_last),
        .pend_keep  (pend_keep),
        .pend_last  (pend_last),
        .data       (data)
    );

    assign entry_ready = !rst && (state != SPLIT) && (!m_axis_tvalid || m_axis_tready);
    assign accept      = entry_valid && entry_ready;
    assign take        = m_axis_tvalid && m_axis_tready;
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            hold_keep     <= '0;
            hold_last     <= 1'b0;
            pkt_count     <= '0;
            proto_err     <= 1'b0;
        end else begin
            if (take && m_axis_tlast) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (accept && err) begin
                proto_err <= 1'b1;
            end

            case (state)
                SPLIT: begin
                    // Both halves share the entry's data, so only the
                    // control fields change when the pending half moves up.
                    if (take) begin
                        m_axis_tkeep <= hold_keep;
                        m_axis_tlast <= hold_last;
                        state        <= FULL;
                    end
                end
                default: begin
                    if (accept && (keep_vec != '0)) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= data;
                        m_axis_tkeep  <= beat1_keep;
                        m_axis_tlast  <= beat1_last;
                        if (split) begin
                            hold_keep <= pend_keep;
                            hold_last <= pend_last;
                            state     <= SPLIT;
                        end else begin
                            state <= FULL;
                        end
                    end else if (take) begin
                        // Either nothing accepted or an empty entry dropped.
                        m_axis_tvalid <= 1'b0;
                        state         <= EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_entry_to_axis.sv
// Directed bench for entry_to_axis: reset/idle, streaming, split, backpressure,
// empty-entry drop, protocol error and reset while a split is pending.
module tb_entry_to_axis;
    import resizer_pkg::*;

    logic                    clk;
    logic                    rst;
    logic [ENTRY_SZ-1:0]     entry_in;
    logic                    entry_valid;
    logic                    entry_ready;
    logic [DATA_SZ-1:0]      m_axis_tdata;
    logic [M_KEEP_WIDTH-1:0] m_axis_tkeep;
    logic                    m_axis_tlast;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic [CNT_WIDTH-1:0]    pkt_count;
    logic                    proto_err;
    logic [1:0]              fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    entry_to_axis dut (
        .clk           (clk),
        .rst           (rst),
        .entry_in      (entry_in),
        .entry_valid   (entry_valid),
        .entry_ready   (entry_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pkt_count     (pkt_count),
        .proto_err     (proto_err),
        .fsm_state     (fsm_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ENTRY_SZ-1:0] mk(input logic k1, input logic l1, input logic [7:0] d1,
                                               input logic k0, input logic l0, input logic [7:0] d0);
        return {k1, l1, d1, k0, l0, d0};
    endfunction

    task automatic chk_beat(input string tag, input logic [15:0] d, input logic [1:0] k,
                            input logic l);
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'(1));
        chk({tag, "_tdata"},  32'(m_axis_tdata),  32'(d));
        chk({tag, "_tkeep"},  32'(m_axis_tkeep),  32'(k));
        chk({tag, "_tlast"},  32'(m_axis_tlast),  32'(l));
    endtask

    logic [15:0] held_data;

    initial begin
        rst           = 1'b1;
        entry_in      = '0;
        entry_valid   = 1'b0;
        m_axis_tready = 1'b1;

        // reset / idle
        tick();
        chk("ready_in_rst", 32'(entry_ready), 32'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("rst_tdata",  32'(m_axis_tdata),  32'(0));
        chk("rst_tkeep",  32'(m_axis_tkeep),  32'(0));
        chk("rst_tlast",  32'(m_axis_tlast),  32'(0));
        chk("rst_pkt",    32'(pkt_count),     32'(0));
        chk("rst_err",    32'(proto_err),     32'(0));
        chk("rst_state",  32'(fsm_state),     32'(EMPTY));
        chk("idle_ready", 32'(entry_ready),   32'(1));

        // stream: two back-to-back entries, second ends the packet
        entry_in    = mk(1, 0, 8'hB2, 1, 0, 8'hA1);
        entry_valid = 1'b1;
        tick();
        chk_beat("stream1", 16'hB2A1, 2'b11, 1'b0);
        entry_in = mk(1, 1, 8'hD4, 1, 0, 8'hC3);
        #1;
        chk("stream_ready", 32'(entry_ready), 32'(1));
        tick();
        entry_valid = 1'b0;
        chk_beat("stream2", 16'hD4C3, 2'b11, 1'b1);
        chk("stream2_pkt", 32'(pkt_count), 32'(0));
        tick();
        chk("stream_pkt", 32'(pkt_count), 32'(1));
        chk("stream_idle", 32'(m_axis_tvalid), 32'(0));

        // split: lane 0 ends a packet, lane 1 is a one-lane packet
        entry_in    = mk(1, 1, 8'h22, 1, 1, 8'h11);
        entry_valid = 1'b1;
        tick();
        entry_valid = 1'b0;
        #1;
        chk_beat("split1", 16'h2211, 2'b01, 1'b1);
        chk("split_state", 32'(fsm_state), 32'(SPLIT));
        chk("split_ready", 32'(entry_ready), 32'(0));
        tick();
        chk("split2_keep", 32'(m_axis_tkeep), 32'(2'b10));
        chk("split2_last", 32'(m_axis_tlast), 32'(1));
        chk("split2_hi",   32'(m_axis_tdata[15:8]), 32'(8'h22));
        chk("split2_valid", 32'(m_axis_tvalid), 32'(1));
        chk("split2_pkt",  32'(pkt_count), 32'(2));
        chk("split2_ready", 32'(entry_ready), 32'(1));
        tick();
        chk("split_pkt", 32'(pkt_count), 32'(3));
        chk("split_idle", 32'(m_axis_tvalid), 32'(0));

        // backpressure: hold a beat for 5 cycles
        m_axis_tready = 1'b0;
        entry_in      = mk(1, 0, 8'h44, 1, 0, 8'h33);
        entry_valid   = 1'b1;
        tick();
        entry_in = mk(1, 0, 8'h66, 1, 0, 8'h55);
        #1;
        held_data = 16'h4433;
        for (int i = 0; i < 5; i++) begin
            chk_beat("bp_hold", held_data, 2'b11, 1'b0);
            chk("bp_ready", 32'(entry_ready), 32'(0));
            tick();
        end
        m_axis_tready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(entry_ready), 32'(1));
        tick();
        chk_beat("bp_next", 16'h6655, 2'b11, 1'b0);
        // empty entry is dropped while the held beat is taken
        entry_in = mk(0, 0, 8'h77, 0, 0, 8'h88);
        tick();
        entry_valid = 1'b0;
        chk("drop_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("drop_state",  32'(fsm_state),     32'(EMPTY));
        chk("drop_pkt",    32'(pkt_count),     32'(3));

        // protocol error: last on an unkept lane
        entry_in    = mk(0, 1, 8'h00, 1, 0, 8'h55);
        entry_valid = 1'b1;
        tick();
        entry_valid = 1'b0;
        chk_beat("err_beat", 16'h0055, 2'b01, 1'b0);
        chk("err_flag", 32'(proto_err), 32'(1));
        tick();
        chk("err_sticky", 32'(proto_err), 32'(1));
        chk("err_pkt", 32'(pkt_count), 32'(3));

        // reset while a split is pending
        m_axis_tready = 1'b0;
        entry_in      = mk(1, 1, 8'hBB, 1, 1, 8'hAA);
        entry_valid   = 1'b1;
        tick();
        entry_valid = 1'b0;
        chk("rsplit_state", 32'(fsm_state), 32'(SPLIT));
        rst = 1'b1;
        #1;
        chk("rsplit_ready_rst", 32'(entry_ready), 32'(0));
        tick();
        chk("rsplit_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("rsplit_err",    32'(proto_err),     32'(0));
        chk("rsplit_pkt",    32'(pkt_count),     32'(0));
        chk("rsplit_state2", 32'(fsm_state),     32'(EMPTY));
        rst           = 1'b0;
        m_axis_tready = 1'b1;
        entry_in      = mk(1, 1, 8'h09, 1, 0, 8'h08);
        entry_valid   = 1'b1;
        tick();
        entry_valid = 1'b0;
        chk_beat("post_rst", 16'h0908, 2'b11, 1'b1);
        tick();
        chk("post_rst_pkt", 32'(pkt_count), 32'(1));
        chk("post_rst_idle", 32'(m_axis_tvalid), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
